// File: rtl/pmod_8led2_seq.sv
// pmod_8led2_seq: prescaled static/chase/bounce/count pattern sequencer for the PMOD 8LED2 green and red banks
module pmod_8led2_seq #(
   parameter int               WIDTH    = 8,
   parameter int               TICK_DIV = 12_500_000,
   parameter logic [WIDTH-1:0] INIT_G   = 8'b10101001,
   parameter logic [WIDTH-1:0] INIT_R   = 8'b01010010
) (
   input  logic             clk_25mhz,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             pause,
   output logic [WIDTH-1:0] pmodledg,
   output logic [WIDTH-1:0] pmodledr,
   output logic             tick
);
   localparam int CW  = $clog2(TICK_DIV);
   localparam int PW  = $clog2(WIDTH);
   localparam int NW  = 2 * WIDTH;
   localparam logic [CW-1:0]    CMAX  = CW'(TICK_DIV - 1);
   localparam logic [PW-1:0]    PMAX  = PW'(WIDTH - 1);
   localparam logic [PW-1:0]    PMAX1 = PW'(WIDTH - 2);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [PW-1:0]    pos_q, pos_d, pos_adv;
   logic             dir_dn_q, dir_dn_d, dir_adv;
   logic [NW-1:0]    count_q, count_d, count_inc;
   logic [WIDTH-1:0] g_q, g_d, r_q, r_d, rot;
   logic             tick_q, tick_d;
   assign pos_adv   = dir_dn_q ? ((pos_q == '0) ? PW'(1) : pos_q - PW'(1))
                               : ((pos_q == PMAX) ? PMAX1 : pos_q + PW'(1));
   assign dir_adv   = dir_dn_q ? (pos_q != '0) : (pos_q == PMAX);
   assign count_inc = count_q + NW'(1);
   assign rot       = {g_q[WIDTH-2:0], g_q[WIDTH-1]};
   assign pmodledg  = g_q;
   assign pmodledr  = r_q;
   assign tick      = tick_q;
   // next state: mode change loads entry state, otherwise prescaler expiry advances the current pattern
   always_comb begin
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      pos_d    = pos_q;
      dir_dn_d = dir_dn_q;
      count_d  = count_q;
      g_d      = g_q;
      r_d      = r_q;
      tick_d   = 1'b0;
      if (mode != mode_q) begin
         mode_d = mode;
         cnt_d  = '0;
         unique case (mode)
            2'd0: begin g_d = INIT_G; r_d = INIT_R; end
            2'd1: begin g_d = ONE; r_d = ~ONE; end
            2'd2: begin pos_d = '0; dir_dn_d = 1'b0; g_d = ONE; r_d = ONE << PMAX; end
            default: begin count_d = '0; g_d = '0; r_d = '0; end
         endcase
      end else if (!pause) begin
         if (cnt_q == CMAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            unique case (mode_q)
               2'd0: g_d = g_q;
               2'd1: begin g_d = rot; r_d = ~rot; end
               2'd2: begin
                  pos_d    = pos_adv;
                  dir_dn_d = dir_adv;
                  g_d      = ONE << pos_adv;
                  r_d      = ONE << (PMAX - pos_adv);
               end
               default: begin count_d = count_inc; g_d = count_inc[WIDTH-1:0]; r_d = count_inc[NW-1:WIDTH]; end
            endcase
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end
   // state registers with asynchronous reset to the static pattern
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         mode_q   <= 2'd0;
         pos_q    <= '0;
         dir_dn_q <= 1'b0;
         count_q  <= '0;
         g_q      <= INIT_G;
         r_q      <= INIT_R;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         pos_q    <= pos_d;
         dir_dn_q <= dir_dn_d;
         count_q  <= count_d;
         g_q      <= g_d;
         r_q      <= r_d;
         tick_q   <= tick_d;
      end
   end
endmodule

// File: tb/tb_pmod_8led2_seq.sv
// tb_pmod_8led2_seq: scoreboard bench for the LED sequencer with WIDTH=8, TICK_DIV=4
module tb_pmod_8led2_seq;
   logic       clk_25mhz = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'd0;
   logic       pause = 1'b0;
   logic [7:0] pmodledg, pmodledr;
   logic       tick;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [15:0] exp_q[$];

   pmod_8led2_seq #(.WIDTH(8), .TICK_DIV(4)) dut (
      .clk_25mhz(clk_25mhz), .reset(reset), .mode(mode), .pause(pause),
      .pmodledg(pmodledg), .pmodledr(pmodledr), .tick(tick)
   );

   always #5 clk_25mhz = ~clk_25mhz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {pmodledg, pmodledr}, e);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_25mhz);
   endtask

   task automatic wait_tick(output int c);
      c = 0;
      do begin
         @(negedge clk_25mhz);
         c++;
      end while (!tick && c < 20);
      if (!tick) chk("tick_timeout", 0, 1);
   endtask

   initial begin
      int c, hits;
      logic [7:0] g;
      int p;
      cycles(2);
      chk("rst_leds", {pmodledg, pmodledr}, 16'hA952);
      chk("rst_tick", tick, 0);
      reset = 1'b0;
      repeat (3) exp_q.push_back(16'hA952);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_25mhz);
         chk("static_tick", tick, (k % 4 == 0));
         if (tick) pop_chk("static_step");
         else chk("static_hold", {pmodledg, pmodledr}, 16'hA952);
      end
      // chase
      mode = 2'd1;
      @(negedge clk_25mhz);
      chk("chase_entry", {pmodledg, pmodledr}, 16'h01FE);
      chk("chase_entry_tick", tick, 0);
      for (int i = 1; i <= 8; i++) begin
         g = 8'h01 << (i % 8);
         exp_q.push_back({g, ~g});
      end
      for (int i = 1; i <= 8; i++) begin
         wait_tick(c);
         chk("chase_period", c, 4);
         pop_chk("chase_step");
      end
      // bounce
      mode = 2'd2;
      @(negedge clk_25mhz);
      chk("bounce_entry", {pmodledg, pmodledr}, 16'h0180);
      for (int i = 1; i <= 15; i++) begin
         p = (i % 14 <= 7) ? i % 14 : 14 - (i % 14);
         exp_q.push_back({8'h01 << p, 8'h01 << (7 - p)});
      end
      hits = 0;
      for (int i = 1; i <= 15; i++) begin
         wait_tick(c);
         if (i <= 14 && pmodledg == 8'h80) hits++;
         pop_chk("bounce_step");
      end
      chk("bounce_end_once", hits, 1);
      // count with wrap via backdoor
      mode = 2'd3;
      @(negedge clk_25mhz);
      chk("count_entry", {pmodledg, pmodledr}, 16'h0000);
      exp_q.push_back(16'h0100);
      exp_q.push_back(16'h0200);
      wait_tick(c);
      pop_chk("count_step");
      wait_tick(c);
      pop_chk("count_step");
      force dut.count_q = 16'hFFFE;
      @(negedge clk_25mhz);
      release dut.count_q;
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h0000);
      wait_tick(c);
      pop_chk("count_ff");
      wait_tick(c);
      chk("count_wrap_tick", tick, 1);
      pop_chk("count_wrap");
      // pause at cnt=3
      cycles(3);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_25mhz);
         chk("pause_no_tick", tick, 0);
      end
      chk("pause_hold", {pmodledg, pmodledr}, 16'h0000);
      pause = 1'b0;
      exp_q.push_back(16'h0100);
      wait_tick(c);
      chk("pause_resume_lat", c, 1);
      pop_chk("pause_resume");
      // mode change at cnt=3 beats the tick
      cycles(3);
      mode = 2'd2;
      @(negedge clk_25mhz);
      chk("prio_no_tick", tick, 0);
      chk("prio_entry", {pmodledg, pmodledr}, 16'h0180);
      exp_q.push_back(16'h0240);
      wait_tick(c);
      chk("prio_next_lat", c, 4);
      pop_chk("prio_step");
      // async reset mid-bounce between edges
      cycles(1);
      #2 reset = 1'b1;
      #1;
      chk("arst_leds", {pmodledg, pmodledr}, 16'hA952);
      chk("arst_tick", tick, 0);
      @(negedge clk_25mhz);
      reset = 1'b0;
      @(negedge clk_25mhz);
      chk("arst_mode_entry", {pmodledg, pmodledr}, 16'h0180);
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pmod_8led2_seq.md
# pmod_8led2_seq

Parametrised LED pattern sequencer driving the two colour banks of the PMOD 8LED2 module on the ULX3S. It generalises the fixed green/red test pattern to a configurable bank width and a programmable update rate, with four run-time selectable modes: static, chase, bounce and binary count. It sits directly between the top-level pins and a mode/pause source such as board buttons or DIP switches.

## Interface

Parameters:
- `WIDTH`, 8: LEDs per colour bank; legal range is 2 or more.
- `TICK_DIV`, 12_500_000: clock cycles per pattern step (0.5 s at 25 MHz); legal range is 2 or more.
- `INIT_G`, 8'b10101001: green pattern for static mode and for reset, `WIDTH` bits.
- `INIT_R`, 8'b01010010: red pattern for static mode and for reset, `WIDTH` bits.

Ports:
- `clk_25mhz`, in, 1: system clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `mode`, in, 2: 0 = static, 1 = chase, 2 = bounce, 3 = count. Synchronous to the clock.
- `pause`, in, 1: while high, the prescaler freezes and the pattern holds.
- `pmodledg`, out, `WIDTH`: green bank, registered, 1 = LED on.
- `pmodledr`, out, `WIDTH`: red bank, registered, 1 = LED on.
- `tick`, out, 1: one-cycle pulse, asserted in the same cycle the new pattern appears.

## Operation

Reset values:
- `cnt` = 0, `tick` = 0, `mode_q` = 0.
- `pos` = 0, `dir` = up, `count` = 0.
- `pmodledg` = `INIT_G`, `pmodledr` = `INIT_R`.

Prescaler:
- `cnt` counts 0 to `TICK_DIV`-1.
- When `cnt` is `TICK_DIV`-1 and `pause` is 0, the next edge sets `cnt` to 0, sets `tick` to 1 and advances the pattern.
- Otherwise `cnt` increments (or holds while `pause` is high) and `tick` is 0.

Mode change:
- When `mode` differs from `mode_q`, the next edge does all of the following:
  - sets `mode_q` to `mode`;
  - sets `cnt` to 0 and keeps `tick` at 0;
  - loads the entry state for the new mode.
- Mode change takes priority over a coincident tick.
- Mode change is processed even while `pause` is high.
- If `mode` is nonzero when reset is released, the first clock edge loads that mode's entry state.

Entry state and per-tick advance, by mode:
- **Static (0):** entry is G=`INIT_G`, R=`INIT_R`. A tick leaves the outputs unchanged; `tick` still pulses.
- **Chase (1):** entry is G=1, R=~1. Each tick rotates G left by one, with the MSB wrapping to the LSB. R is always ~G.
- **Bounce (2):** entry is `pos`=0, `dir`=up, G=1<<0, R=1<<(`WIDTH`-1).
  - Each tick moves `pos` up or down by one according to `dir`.
  - At the ends, when up at `WIDTH`-1, the step sets `pos` to `WIDTH`-2 and `dir` to down. When down at 0, it sets `pos` to 1 and `dir` to up.
  - G = 1<<`pos`, R = 1<<(`WIDTH`-1-`pos`).
  - Period is 2·`WIDTH`-2 ticks, and end LEDs are not repeated.
- **Count (3):** entry is `count`=0 and G=R=0.
  - `count` is 2·`WIDTH` bits, +1 per tick, wrapping from all-ones to 0.
  - G = `count`[`WIDTH`-1:0], R = `count`[2·`WIDTH`-1:`WIDTH`].

## Timing

- Step period is exactly `TICK_DIV` cycles with `pause` low.
  - The first tick after reset or a mode change comes `TICK_DIV` edges after the edge that cleared `cnt`.
- Outputs and `tick` are registered. The pattern change and the `tick` pulse are visible in the same cycle. There is no combinational path from inputs to outputs.
- Pause:
  - `pause` rising in the cycle where `cnt`=`TICK_DIV`-1 suppresses that tick.
  - After `pause` falls, counting resumes from the held `cnt` value.
- Asserting `reset` mid-operation forces all reset values immediately, without waiting for a clock edge.

## Test plan

All scenarios use `WIDTH`=8 and `TICK_DIV`=4.

- **Reset:** assert `reset` with `mode`=0, release it, run 12 cycles. Required: G=0xA9 and R=0x52 throughout; `tick` high on cycles 4, 8 and 12; outputs unchanged at each tick.
- **Chase:** set `mode`=1. Required: the edge after the change gives G=0x01, R=0xFE. After 8 ticks G has stepped 0x02, 0x04 … 0x80, then 0x01, with R=~G at every step.
- **Bounce:** set `mode`=2 and run 15 ticks. Required:
  - G position sequence 1,2,…,7,6,…,0,1;
  - R position is 7-pos at every step;
  - G=0x80 occurs exactly once per 14-tick period.
- **Count wrap:** `mode`=3, with `count` forced via 65535 ticks or a bench backdoor. Required: the next tick after G=R=0xFF gives G=R=0x00 together with a `tick` pulse.
- **Pause and mode-change priority:**
  - Assert `pause` at `cnt`=3. Required: no tick while held; the first tick comes 1 cycle after release.
  - Change `mode` in the cycle where `cnt`=3. Required: no tick that cycle; the entry state loads; the next tick comes 4 cycles later.
- **Async reset:** assert `reset` mid-bounce between clock edges. Required: outputs return to 0xA9/0x52 and `tick`=0 before the next clock edge.
